// File: rtl/vga_sync_decoder.sv
// Sink-side VGA timing decoder: rebuilds x/y from an active-low hsync/vsync pair,
// checks every sync edge against the configured timing, and tracks lock and errors.
//
// state  | meaning
// SEARCH | no timing reference yet; violations ignored, waiting for a vsync fall
// CHECK  | one vsync fall seen; a clean frame up to the next vsync fall gives lock
// LOCKED | timing verified; any violation drops back to SEARCH
module vga_sync_decoder #(
   parameter logic [9:0] HACTIVE = 10'd640,
   parameter logic [9:0] HFP     = 10'd16,
   parameter logic [9:0] HSYN    = 10'd96,
   parameter logic [9:0] HBP     = 10'd48,
   parameter logic [9:0] VACTIVE = 10'd480,
   parameter logic [9:0] VFP     = 10'd10,
   parameter logic [9:0] VSYN    = 10'd2,
   parameter logic [9:0] VBP     = 10'd33,
   parameter logic [9:0] HMAX    = HACTIVE + HFP + HSYN + HBP,
   parameter logic [9:0] VMAX    = VACTIVE + VFP + VSYN + VBP
) (
   input  logic       vgaclk,
   input  logic       rst,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pixel_valid,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [9:0] H_SYNC_X = HACTIVE + HFP;
   localparam logic [9:0] V_SYNC_Y = VACTIVE + VFP;
   localparam logic [9:0] H_LAST   = HMAX - 10'd1;
   localparam logic [9:0] V_LAST   = VMAX - 10'd1;

   state_t     state;
   state_t     state_nxt;
   logic       hs_q;
   logic       vs_q;
   logic       hedge;
   logic       vedge;
   logic       h_wrap;
   logic       h_exp;
   logic       v_exp;
   logic       viol;
   logic       err_nxt;
   logic       lock_nxt;
   logic [9:0] x_nxt;
   logic [9:0] y_nxt;

   assign hedge   = hs_q & ~hsync;
   assign vedge   = vs_q & ~vsync;
   assign h_wrap  = (x == H_LAST);
   // An edge is expected on the sample where the generator's counter hits the sync start;
   // our counters trail it by one cycle, hence the -1.
   assign h_exp   = (x == H_SYNC_X - 10'd1);
   assign v_exp   = h_wrap & (y == V_SYNC_Y - 10'd1);
   assign viol    = (hedge ^ h_exp) | (vedge ^ v_exp);
   assign err_nxt = viol & (state != SEARCH);

   always_comb begin
      x_nxt     = x + 10'd1;
      y_nxt     = y;
      state_nxt = state;

      if (hedge) begin
         x_nxt = H_SYNC_X;
      end else if (h_wrap) begin
         x_nxt = 10'd0;
      end

      if (vedge) begin
         y_nxt = V_SYNC_Y;
      end else if (h_wrap && !hedge) begin
         y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
      end

      case (state)
         SEARCH: if (vedge) state_nxt = CHECK;
         CHECK: begin
            if (viol) begin
               state_nxt = SEARCH;
            end else if (vedge) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: if (viol) state_nxt = SEARCH;
         default: state_nxt = SEARCH;
      endcase
   end

   assign lock_nxt = (state_nxt == LOCKED);

   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         state       <= SEARCH;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         x           <= 10'd0;
         y           <= 10'd0;
         locked      <= 1'b0;
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         state       <= state_nxt;
         hs_q        <= hsync;
         vs_q        <= vsync;
         x           <= x_nxt;
         y           <= y_nxt;
         locked      <= lock_nxt;
         pixel_valid <= lock_nxt & (x_nxt < HACTIVE) & (y_nxt < VACTIVE);
         frame_start <= lock_nxt & (x_nxt == 10'd0) & (y_nxt == 10'd0);
         sync_err    <= err_nxt;
         if (err_nxt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using reduced timing (16x9 frame) so lock
// and relock happen within a few hundred cycles.
module tb_vga_sync_decoder;

   localparam int HA  = 8;
   localparam int HF  = 2;
   localparam int HS  = 3;
   localparam int HB  = 3;
   localparam int VA  = 4;
   localparam int VF  = 1;
   localparam int VS  = 2;
   localparam int VB  = 2;
   localparam int HM  = HA + HF + HS + HB;
   localparam int VM  = VA + VF + VS + VB;
   localparam int HS0 = HA + HF;
   localparam int HS1 = HA + HF + HS;
   localparam int VS0 = VA + VF;
   localparam int VS1 = VA + VF + VS;

   logic       vgaclk = 1'b0;
   logic       rst    = 1'b1;
   logic       hsync  = 1'b1;
   logic       vsync  = 1'b1;
   logic [9:0] x;
   logic [9:0] y;
   logic       pixel_valid;
   logic       locked;
   logic       frame_start;
   logic       sync_err;
   logic [7:0] err_count;

   int   compared   = 0;
   int   mismatched = 0;
   int   gx = 0;
   int   gy = 0;
   int   last_x = 0;
   int   last_y = 0;
   logic hs_force = 1'b0;

   vga_sync_decoder #(
      .HACTIVE(10'(HA)), .HFP(10'(HF)), .HSYN(10'(HS)), .HBP(10'(HB)),
      .VACTIVE(10'(VA)), .VFP(10'(VF)), .VSYN(10'(VS)), .VBP(10'(VB))
   ) dut (
      .vgaclk(vgaclk),
      .rst(rst),
      .hsync(hsync),
      .vsync(vsync),
      .x(x),
      .y(y),
      .pixel_valid(pixel_valid),
      .locked(locked),
      .frame_start(frame_start),
      .sync_err(sync_err),
      .err_count(err_count)
   );

   always #5 vgaclk = ~vgaclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One generator cycle: drive syncs for (gx,gy), let the DUT sample, then advance.
   task automatic tick();
      @(negedge vgaclk);
      hsync = !((gx >= HS0) && (gx < HS1)) || hs_force;
      vsync = !((gy >= VS0) && (gy < VS1));
      @(posedge vgaclk);
      #1;
      last_x = gx;
      last_y = gy;
      if (gx == HM - 1) begin
         gx = 0;
         gy = (gy == VM - 1) ? 0 : gy + 1;
      end else begin
         gx = gx + 1;
      end
   endtask

   task automatic run_to(input int tx, input int ty);
      for (int i = 0; i < 200; i++) begin
         if (gx == tx && gy == ty) break;
         tick();
      end
   endtask

   initial begin
      int first_lock;
      int vf;
      int early;
      int found;

      // reset state
      repeat (2) @(posedge vgaclk);
      #1;
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_locked", locked, 0);
      check("rst_pv", pixel_valid, 0);
      check("rst_fs", frame_start, 0);
      check("rst_err", sync_err, 0);
      check("rst_cnt", err_count, 0);
      @(negedge vgaclk);
      rst = 1'b0;

      // first lock: vsync falls sampled at ticks 80 and 224
      first_lock = -1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (locked && first_lock < 0) begin
            first_lock = k;
            break;
         end
      end
      check("lock_latency", first_lock, 224);

      // three locked frames track the generator with one cycle of lag
      for (int k = 0; k < 3 * HM * VM; k++) begin
         tick();
         check("trk_x", x, last_x);
         check("trk_y", y, last_y);
         check("trk_pv", pixel_valid, (last_x < HA) && (last_y < VA));
         check("trk_fs", frame_start, (last_x == 0) && (last_y == 0));
         check("trk_err", sync_err, 0);
      end
      check("trk_cnt", err_count, 0);
      check("trk_locked", locked, 1);

      // one hsync fall delayed by a cycle: missing edge counted, late edge seen in SEARCH
      run_to(HS0, 1);
      hs_force = 1'b1;
      tick();
      hs_force = 1'b0;
      check("dly_err1", sync_err, 1);
      check("dly_locked", locked, 0);
      check("dly_pv", pixel_valid, 0);
      tick();
      check("dly_err2", sync_err, 0);
      check("dly_x", x, HS0);
      check("dly_cnt", err_count, 1);

      vf = 0;
      early = 0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (last_x == 0 && last_y == VS0) vf++;
         if (vf < 2 && locked) early = 1;
         if (vf == 2) break;
      end
      check("relock_early", early, 0);
      check("relock", locked, 1);

      // a whole line with no hsync pulse: one error, x free-runs through the wrap
      run_to(HS0, 1);
      hs_force = 1'b1;
      tick();
      check("miss_err1", sync_err, 1);
      check("miss_locked", locked, 0);
      tick();
      check("miss_err2", sync_err, 0);
      check("miss_cnt", err_count, 2);
      tick();
      hs_force = 1'b0;
      run_to(HM - 1, 1);
      tick();
      check("miss_x_end", x, HM - 1);
      check("miss_y_end", y, 1);
      tick();
      check("miss_x_wrap", x, 0);
      check("miss_y_inc", y, 2);
      check("miss_cnt2", err_count, 2);

      // vsync held low through reset release: only genuine falls count
      @(negedge vgaclk);
      rst   = 1'b1;
      hsync = 1'b1;
      vsync = 1'b0;
      repeat (2) @(posedge vgaclk);
      @(negedge vgaclk);
      rst = 1'b0;
      gx  = 0;
      gy  = VS0;
      first_lock = -1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (locked && first_lock < 0) begin
            first_lock = k;
            break;
         end
      end
      check("vlow_lock", first_lock, 288);
      check("vlow_cnt", err_count, 0);

      // asynchronous reset mid-line while locked
      found = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (last_x == 5 && last_y == 2) begin
            found = 1;
            break;
         end
      end
      check("pre_rst_found", found, 1);
      check("pre_rst_x", x, 5);
      check("pre_rst_y", y, 2);
      check("pre_rst_locked", locked, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_x", x, 0);
      check("arst_y", y, 0);
      check("arst_locked", locked, 0);
      check("arst_pv", pixel_valid, 0);
      check("arst_fs", frame_start, 0);
      check("arst_err", sync_err, 0);
      tick();
      tick();
      rst = 1'b0;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (last_x == HS0) begin
            found = 1;
            break;
         end
      end
      check("resync_found", found, 1);
      check("resync_x", x, HS0);
      check("resync_locked", locked, 0);

      // rapid vsync toggling forces several hundred violations
      for (int i = 0; i < 2000; i++) begin
         @(negedge vgaclk);
         hsync = 1'b1;
         vsync = i[0];
         @(posedge vgaclk);
      end
      #1;
      check("sat_cnt", err_count, 255);
      repeat (20) begin
         @(negedge vgaclk);
         vsync = ~vsync;
      end
      @(posedge vgaclk);
      #1;
      check("sat_hold", err_count, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
